// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C target state encoding and bus constants
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } i2c_state_t;
  localparam logic I2C_RW_READ = 1'b1;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: synchronizes SCL/SDA and derives START/STOP and SCL edge strobes
module i2c_bus_cond (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  assign sda = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with auto-incrementing pointer register file and host side port
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int NUM_REGS = 16,
  localparam int PTR_W = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_oen_o,
  input  logic [PTR_W-1:0] hst_addr_i,
  output logic [7:0]       hst_rdata_o,
  output logic             wr_stb_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             busy_o
);
  i2c_state_t state, state_n;
  logic sda, scl_rise, scl_fall, start, stop;
  logic [3:0] cnt;
  logic [7:0] shreg, byte_in, cur;
  logic rw, mst_ack, byte_done, ack_fall, match;
  logic [PTR_W-1:0] ptr;
  logic [7:0] regs [NUM_REGS];
  i2c_bus_cond u_cond (
    .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i),
    .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  assign sda_o = 1'b0;
  assign byte_in = {shreg[6:0], sda};
  assign cur = regs[ptr];
  assign byte_done = scl_rise && cnt == 4'd7;
  assign ack_fall = scl_fall && cnt == 4'd8;
  assign match = byte_in[7:1] == I2C_ADDR && I2C_ADDR != 7'd0;
  always_comb begin
    state_n = state;
    if (stop) state_n = IDLE;
    else if (start) state_n = ADDR;
    else case (state)
      ADDR: state_n = byte_done && !match ? IGNORE : ack_fall ? ADDR_ACK : ADDR;
      ADDR_ACK: state_n = scl_fall ? (rw == I2C_RW_READ ? RDATA : PTR) : ADDR_ACK;
      PTR: state_n = ack_fall ? PTR_ACK : PTR;
      PTR_ACK, WDATA_ACK: state_n = scl_fall ? WDATA : state;
      WDATA: state_n = ack_fall ? WDATA_ACK : WDATA;
      RDATA: state_n = scl_fall && cnt == 4'd7 ? RDATA_ACK : RDATA;
      RDATA_ACK: state_n = scl_fall ? (mst_ack == ACK ? RDATA : IGNORE) : RDATA_ACK;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt <= '0;
      shreg <= '0;
      rw <= 1'b0;
      mst_ack <= ACK;
      ptr <= '0;
      sda_oen_o <= 1'b0;
      busy_o <= 1'b0;
      wr_stb_o <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      hst_rdata_o <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_stb_o <= 1'b0;
      hst_rdata_o <= regs[hst_addr_i];
      if (stop) begin
        sda_oen_o <= 1'b0;
        busy_o <= 1'b0;
      end else if (start) begin
        sda_oen_o <= 1'b0;
        cnt <= '0;
      end else case (state)
        ADDR, PTR, WDATA:
          if (scl_rise && cnt != 4'd8) begin
            shreg <= byte_in;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7 && state == ADDR) begin
              busy_o <= match;
              rw <= sda;
            end
            if (cnt == 4'd7 && state == PTR) ptr <= byte_in[PTR_W-1:0];
            if (cnt == 4'd7 && state == WDATA) begin
              regs[ptr] <= byte_in;
              wr_stb_o <= 1'b1;
              wr_addr_o <= ptr;
              wr_data_o <= byte_in;
              ptr <= ptr + 1'b1;
            end
          end else if (ack_fall) sda_oen_o <= 1'b1;
        ADDR_ACK, PTR_ACK, WDATA_ACK:
          if (scl_fall) begin
            cnt <= '0;
            shreg <= cur;
            sda_oen_o <= state == ADDR_ACK && rw == I2C_RW_READ && !cur[7];
          end
        RDATA:
          if (scl_fall) begin
            cnt <= cnt + 4'd1;
            shreg <= {shreg[6:0], 1'b0};
            sda_oen_o <= cnt != 4'd7 && !shreg[6];
          end
        RDATA_ACK:
          if (scl_rise) begin
            mst_ack <= sda;
            ptr <= ptr + 1'b1;
          end else if (scl_fall) begin
            cnt <= '0;
            shreg <= cur;
            sda_oen_o <= mst_ack == ACK && !cur[7];
          end
        default: sda_oen_o <= 1'b0;
      endcase
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: randomized I2C master exercising the target against a register-file model
module tb_i2c_target_regfile;
  import i2c_pkg::*;
  localparam int N = 16;
  localparam int Q = 50;
  logic clk = 1'b0, rst_i = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic sda_o, sda_oen_o, wr_stb_o, busy_o, sda_bus, a;
  logic [3:0] hst_addr = '0, wr_addr_o;
  logic [7:0] hst_rdata_o, wr_data_o;
  logic [7:0] mregs [N];
  logic [7:0] wq [$];
  logic [11:0] exp_q [$], got_q [$];
  logic oen_seen, busy_seen;
  int mptr = 0, n_tests = 0, n_fail = 0;
  assign sda_bus = sda_m & ~sda_oen_o;
  i2c_target_regfile dut (
    .clk_i(clk), .rst_i(rst_i), .scl_i(scl), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_oen_o(sda_oen_o), .hst_addr_i(hst_addr), .hst_rdata_o(hst_rdata_o),
    .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_stb_o) got_q.push_back({wr_addr_o, wr_data_o});
    if (sda_oen_o) oen_seen = 1'b1;
    if (busy_o) busy_seen = 1'b1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic bit_w(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask
  task automatic bit_r(output logic b);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask
  task automatic start_c;
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask
  task automatic stop_c;
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask
  task automatic byte_w(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(ack);
  endtask
  task automatic byte_r(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    bit_w(ack);
  endtask
  task automatic chk_stb;
    chk("stb_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) chk("stb_addr_data", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic side_chk(input int idx);
    @(negedge clk);
    hst_addr = 4'(idx);
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("side_rd[%0d]", idx), hst_rdata_o, mregs[idx]);
  endtask
  task automatic wr_txn(input logic [7:0] p);
    logic ack;
    start_c;
    byte_w(8'hA0, ack);
    chk("wr_addr_ack", ack, ACK);
    chk("wr_busy", busy_o, 1);
    byte_w(p, ack);
    chk("wr_ptr_ack", ack, ACK);
    mptr = p % N;
    foreach (wq[i]) begin
      byte_w(wq[i], ack);
      chk("wr_data_ack", ack, ACK);
      mregs[mptr] = wq[i];
      exp_q.push_back({4'(mptr), wq[i]});
      mptr = (mptr + 1) % N;
    end
    stop_c;
    chk("wr_busy_after_stop", busy_o, 0);
    chk_stb();
  endtask
  task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    start_c;
    if (set_ptr) begin
      byte_w(8'hA0, ack);
      chk("rd_waddr_ack", ack, ACK);
      byte_w(p, ack);
      chk("rd_ptr_ack", ack, ACK);
      mptr = p % N;
      start_c;
    end
    byte_w(8'hA1, ack);
    chk("rd_addr_ack", ack, ACK);
    for (int i = 0; i < n; i++) begin
      byte_r(d, i == n - 1 ? NACK : ACK);
      chk("rd_data", d, mregs[mptr]);
      mptr = (mptr + 1) % N;
    end
    stop_c;
    chk("rd_busy_after_stop", busy_o, 0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) mregs[i] = '0;
    repeat (5) @(negedge clk);
    chk("rst_oen", sda_oen_o, 0);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stb", wr_stb_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_rdata", hst_rdata_o, 0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    side_chk(3);
    wq = '{8'h5C};
    wr_txn(8'h05);
    wq = '{8'h11, 8'h22};
    wr_txn(8'h03);
    side_chk(3);
    side_chk(4);
    rd_txn(1'b1, 8'h03, 2);
    rd_txn(1'b0, 8'h00, 1);
    oen_seen = 1'b0;
    busy_seen = 1'b0;
    start_c;
    byte_w(8'hA2, a);
    chk("mm_addr_nack", a, NACK);
    byte_w(8'h00, a);
    byte_w(8'h55, a);
    stop_c;
    start_c;
    byte_w(8'h00, a);
    chk("gcall_nack", a, NACK);
    byte_w(8'h77, a);
    stop_c;
    chk("mm_oen_seen", oen_seen, 0);
    chk("mm_busy_seen", busy_seen, 0);
    chk_stb();
    side_chk(0);
    wq = '{8'hAA, 8'hBB};
    wr_txn(8'h1F);
    side_chk(15);
    side_chk(0);
    wq = '{8'h9D};
    wr_txn(8'h02);
    start_c;
    byte_w(8'hA0, a);
    byte_w(8'h02, a);
    for (int i = 0; i < 5; i++) bit_w(1'($urandom_range(1)));
    stop_c;
    chk("abort_busy", busy_o, 0);
    chk_stb();
    side_chk(2);
    wq = '{8'h3C};
    wr_txn(8'h02);
    side_chk(2);
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(1) == 1) begin
        wq.delete();
        for (int k = 0; k < $urandom_range(4, 1); k++) wq.push_back(8'($urandom));
        wr_txn(8'($urandom));
      end else rd_txn(1'($urandom_range(1)), 8'($urandom), $urandom_range(4, 1));
    end
    for (int i = 0; i < N; i++) side_chk(i);
    wq = '{8'h00};
    wr_txn(8'h06);
    start_c;
    byte_w(8'hA0, a);
    byte_w(8'h06, a);
    start_c;
    byte_w(8'hA1, a);
    chk("pre_rst_drive", sda_oen_o, 1);
    #3;
    rst_i = 1'b1;
    #1;
    chk("rst_async_release", sda_oen_o, 0);
    for (int i = 0; i < N; i++) mregs[i] = '0;
    repeat (3) @(negedge clk);
    scl = 1'b1;
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < N; i++) side_chk(i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
